// File: rtl/auto_exposure_ctrl.sv
// Closed-loop auto exposure: green mean from per-frame bayer statistics via a
// restoring divider, deadband compare against target, clamped exposure stepping.
module auto_exposure_ctrl #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned ACCUM_WIDTH = 30,
    parameter int unsigned COUNT_WIDTH = 22,
    parameter int unsigned EXP_WIDTH   = 16,
    parameter int unsigned EXP_RESET   = 512
) (
    input  logic                   pixclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PIXEL_WIDTH-1:0] target,
    input  logic [PIXEL_WIDTH-1:0] deadband,
    input  logic [3:0]             step_shift,
    input  logic [EXP_WIDTH-1:0]   exp_min,
    input  logic [EXP_WIDTH-1:0]   exp_max,
    input  logic [3:0]             settle_frames,
    input  logic [COUNT_WIDTH+1:0] sat_limit,
    input  logic                   stats_done,
    input  logic [ACCUM_WIDTH-1:0] accum01,
    input  logic [ACCUM_WIDTH-1:0] accum10,
    input  logic [COUNT_WIDTH-1:0] accum_count,
    input  logic [COUNT_WIDTH+1:0] sat_pix_count,
    output logic [EXP_WIDTH-1:0]   exposure,
    output logic                   exposure_valid,
    output logic [PIXEL_WIDTH-1:0] mean,
    output logic                   mean_valid,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(ACCUM_WIDTH + 2);

    typedef enum logic [1:0] {IDLE, DIVIDE, ADJUST} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_q;
    logic [ACCUM_WIDTH:0]   quo_q, quo_d;
    logic [ACCUM_WIDTH+1:0] rem_q, rem_d, rem_shift;
    logic [COUNT_WIDTH:0]   div_q;
    logic [COUNT_WIDTH+1:0] sat_q;
    logic [PIXEL_WIDTH-1:0] qsat_q, qsat_d;
    logic [3:0]             settle_q;
    logic [EXP_WIDTH-1:0]   exposure_q, exp_new_d;
    logic                   exposure_valid_q, mean_valid_q;
    logic [PIXEL_WIDTH-1:0] mean_q;

    logic [PIXEL_WIDTH:0]   mean_x, tgt_x, mean_db, tgt_db;
    logic                   inc, dec;
    logic [EXP_WIDTH-1:0]   shifted, delta, dec_raw;
    logic [EXP_WIDTH:0]     cand, lo_clamped, hi_clamped;

    // Dividend shifts out of quo_q MSB-first while quotient bits shift in.
    always_comb begin
        rem_shift = {rem_q[ACCUM_WIDTH:0], quo_q[ACCUM_WIDTH]};
        rem_d     = rem_shift;
        quo_d     = {quo_q[ACCUM_WIDTH-1:0], 1'b0};
        if (rem_shift >= (ACCUM_WIDTH+2)'(div_q)) begin
            rem_d = rem_shift - (ACCUM_WIDTH+2)'(div_q);
            quo_d = {quo_q[ACCUM_WIDTH-1:0], 1'b1};
        end
        qsat_d = (|quo_q[ACCUM_WIDTH:PIXEL_WIDTH]) ? '1 : quo_q[PIXEL_WIDTH-1:0];
    end

    always_comb begin
        mean_x  = {1'b0, qsat_q};
        tgt_x   = {1'b0, target};
        mean_db = mean_x + {1'b0, deadband};
        tgt_db  = tgt_x + {1'b0, deadband};
        dec     = (sat_q > sat_limit) || (mean_x > tgt_db);
        inc     = !dec && (mean_db < tgt_x);

        shifted = exposure_q >> step_shift;
        delta   = (shifted == '0) ? EXP_WIDTH'(1) : shifted;
        dec_raw = (exposure_q >= delta) ? exposure_q - delta : '0;
        cand    = inc ? {1'b0, exposure_q} + {1'b0, delta} : {1'b0, dec_raw};

        // Low clamp before high clamp keeps a misconfigured window in range.
        lo_clamped = (cand < {1'b0, exp_min}) ? {1'b0, exp_min} : cand;
        hi_clamped = (lo_clamped > {1'b0, exp_max}) ? {1'b0, exp_max} : lo_clamped;
        exp_new_d  = (inc || dec) ? hi_clamped[EXP_WIDTH-1:0] : exposure_q;
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            bit_q            <= '0;
            quo_q            <= '0;
            rem_q            <= '0;
            div_q            <= '0;
            sat_q            <= '0;
            qsat_q           <= '0;
            settle_q         <= '0;
            exposure_q       <= EXP_WIDTH'(EXP_RESET);
            exposure_valid_q <= 1'b0;
            mean_q           <= '0;
            mean_valid_q     <= 1'b0;
        end else begin
            exposure_valid_q <= 1'b0;
            mean_valid_q     <= 1'b0;
            if (!enable) begin
                state_q  <= IDLE;
                settle_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (stats_done) begin
                            if (settle_q != '0) begin
                                settle_q <= settle_q - 4'd1;
                            end else if (accum_count != '0) begin
                                quo_q   <= {1'b0, accum01} + {1'b0, accum10};
                                div_q   <= {accum_count, 1'b0};
                                rem_q   <= '0;
                                sat_q   <= sat_pix_count;
                                bit_q   <= '0;
                                state_q <= DIVIDE;
                            end
                        end
                    end
                    // One quotient bit per cycle, then a final cycle registers the saturated quotient.
                    DIVIDE: begin
                        if (bit_q == CNT_W'(ACCUM_WIDTH + 1)) begin
                            qsat_q  <= qsat_d;
                            state_q <= ADJUST;
                        end else begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    ADJUST: begin
                        mean_q       <= qsat_q;
                        mean_valid_q <= 1'b1;
                        if (exp_new_d != exposure_q) begin
                            exposure_q       <= exp_new_d;
                            exposure_valid_q <= 1'b1;
                            settle_q         <= settle_frames;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign exposure       = exposure_q;
    assign exposure_valid = exposure_valid_q;
    assign mean           = mean_q;
    assign mean_valid     = mean_valid_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_auto_exposure_ctrl.sv
// Directed bench for auto_exposure_ctrl; expected values hand-computed from the
// divide/deadband/step/clamp rules, checked 33 edges after the statistics pulse.
module tb_auto_exposure_ctrl;

    logic        pixclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  target = 8'd128;
    logic [7:0]  deadband = 8'd4;
    logic [3:0]  step_shift = 4'd0;
    logic [15:0] exp_min = 16'd0;
    logic [15:0] exp_max = 16'd800;
    logic [3:0]  settle_frames = 4'd0;
    logic [23:0] sat_limit = 24'd1000000;
    logic        stats_done = 1'b0;
    logic [29:0] accum01 = '0;
    logic [29:0] accum10 = '0;
    logic [21:0] accum_count = '0;
    logic [23:0] sat_pix_count = '0;
    logic [15:0] exposure;
    logic        exposure_valid;
    logic [7:0]  mean;
    logic        mean_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int mv_cyc, ev_cyc, mv_n, ev_n;
    logic busy_mid;

    auto_exposure_ctrl #(
        .PIXEL_WIDTH(8), .ACCUM_WIDTH(30), .COUNT_WIDTH(22), .EXP_WIDTH(16), .EXP_RESET(512)
    ) dut (
        .pixclk(pixclk), .reset(reset), .enable(enable), .target(target),
        .deadband(deadband), .step_shift(step_shift), .exp_min(exp_min),
        .exp_max(exp_max), .settle_frames(settle_frames), .sat_limit(sat_limit),
        .stats_done(stats_done), .accum01(accum01), .accum10(accum10),
        .accum_count(accum_count), .sat_pix_count(sat_pix_count),
        .exposure(exposure), .exposure_valid(exposure_valid), .mean(mean),
        .mean_valid(mean_valid), .busy(busy)
    );

    always #5 pixclk = ~pixclk;

    // One frame pulse, then 45 observed edges; optional second pulse at edge inj
    // and enable dropped for the single edge en_off (0 disables either).
    task automatic run_frame(input logic [29:0] a, input logic [21:0] cnt,
                             input logic [23:0] sat, input int inj, input int en_off);
        @(negedge pixclk);
        accum01 = a; accum10 = a; accum_count = cnt; sat_pix_count = sat;
        stats_done = 1'b1;
        @(posedge pixclk);
        mv_cyc = 0; ev_cyc = 0; mv_n = 0; ev_n = 0; busy_mid = 1'bx;
        for (int k = 1; k <= 45; k++) begin
            @(negedge pixclk);
            stats_done = (k == inj);
            if (k == inj) begin
                accum01 = 30'd200000; accum10 = 30'd200000; accum_count = 22'd1000;
            end
            enable = (k != en_off);
            @(posedge pixclk);
            #1;
            if (mean_valid === 1'b1) begin mv_n++; if (mv_cyc == 0) mv_cyc = k; end
            if (exposure_valid === 1'b1) begin ev_n++; if (ev_cyc == 0) ev_cyc = k; end
            if (k == 10) busy_mid = busy;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge pixclk);
        #1;
        checks++; if (exposure !== 16'd512) begin errors++; $display("FAIL reset_exposure: got %0d expected 512", exposure); end
        checks++; if (mean !== 8'd0) begin errors++; $display("FAIL reset_mean: got %0d expected 0", mean); end
        checks++; if ({busy, mean_valid, exposure_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, mean_valid, exposure_valid}); end
        @(negedge pixclk);
        reset = 1'b0;
    endtask

    task automatic test_increase;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd800) begin errors++; $display("FAIL inc_max_clamp: got %0d expected 800", exposure); end
        step_shift = 4'd3; exp_max = 16'd2000;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mean !== 8'd100) begin errors++; $display("FAIL inc_mean: got %0d expected 100", mean); end
        checks++; if (exposure !== 16'd900) begin errors++; $display("FAIL inc_exposure: got %0d expected 900", exposure); end
        checks++; if (mv_cyc !== 33) begin errors++; $display("FAIL inc_mean_latency: got %0d expected 33", mv_cyc); end
        checks++; if (ev_cyc !== 33) begin errors++; $display("FAIL inc_exp_latency: got %0d expected 33", ev_cyc); end
        checks++; if (mv_n !== 1 || ev_n !== 1) begin errors++; $display("FAIL inc_pulse_width: got %0d/%0d expected 1/1", mv_n, ev_n); end
    endtask

    task automatic test_decrease;
        run_frame(30'd200000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mean !== 8'd200) begin errors++; $display("FAIL dec_mean: got %0d expected 200", mean); end
        checks++; if (exposure !== 16'd788) begin errors++; $display("FAIL dec_exposure: got %0d expected 788", exposure); end
        checks++; if (ev_cyc !== 33) begin errors++; $display("FAIL dec_latency: got %0d expected 33", ev_cyc); end
        run_frame(30'd300000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mean !== 8'd255) begin errors++; $display("FAIL mean_saturate: got %0d expected 255", mean); end
        checks++; if (exposure !== 16'd690) begin errors++; $display("FAIL sat_mean_dec: got %0d expected 690", exposure); end
    endtask

    task automatic test_hold;
        run_frame(30'd126000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mean !== 8'd126 || mv_n !== 1) begin errors++; $display("FAIL hold_mean: got %0d/%0d expected 126/1", mean, mv_n); end
        checks++; if (ev_n !== 0 || exposure !== 16'd690) begin errors++; $display("FAIL hold_exposure: got %0d/%0d expected 690/0", exposure, ev_n); end
        run_frame(30'd124000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mean !== 8'd124 || ev_n !== 0) begin errors++; $display("FAIL hold_low_edge: got %0d/%0d expected 124/0", mean, ev_n); end
        run_frame(30'd132000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mean !== 8'd132 || ev_n !== 0) begin errors++; $display("FAIL hold_high_edge: got %0d/%0d expected 132/0", mean, ev_n); end
        run_frame(30'd100000, 22'd0, 24'd0, 0, 0);
        checks++; if (mv_n !== 0 || ev_n !== 0) begin errors++; $display("FAIL zero_count: got %0d/%0d expected 0/0", mv_n, ev_n); end
        checks++; if (mean !== 8'd132 || exposure !== 16'd690) begin errors++; $display("FAIL zero_count_state: got %0d/%0d expected 132/690", mean, exposure); end
    endtask

    task automatic test_clamp;
        step_shift = 4'd0; exp_max = 16'd1000;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd1000) begin errors++; $display("FAIL clamp_setup: got %0d expected 1000", exposure); end
        step_shift = 4'd3; exp_max = 16'd1020;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd1020) begin errors++; $display("FAIL clamp_max: got %0d expected 1020", exposure); end
        step_shift = 4'd0; exp_min = 16'd10;
        run_frame(30'd200000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd10) begin errors++; $display("FAIL clamp_min_underflow: got %0d expected 10", exposure); end
        step_shift = 4'd4; exp_min = 16'd8;
        run_frame(30'd200000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd9) begin errors++; $display("FAIL min_delta_one: got %0d expected 9", exposure); end
    endtask

    task automatic test_sat_override;
        sat_limit = 24'd100;
        run_frame(30'd100000, 22'd1000, 24'd100, 0, 0);
        checks++; if (exposure !== 16'd10) begin errors++; $display("FAIL sat_equal_no_override: got %0d expected 10", exposure); end
        run_frame(30'd100000, 22'd1000, 24'd5000, 0, 0);
        checks++; if (exposure !== 16'd9 || mean !== 8'd100) begin errors++; $display("FAIL sat_override: got %0d/%0d expected 9/100", exposure, mean); end
        sat_limit = 24'd1000000;
    endtask

    task automatic test_settle;
        step_shift = 4'd0; settle_frames = 4'd2;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd18) begin errors++; $display("FAIL settle_change: got %0d expected 18", exposure); end
        settle_frames = 4'd0;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mv_n !== 0 || exposure !== 16'd18) begin errors++; $display("FAIL settle_skip: got %0d/%0d expected 0/18", mv_n, exposure); end
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (mv_n !== 1 || exposure !== 16'd36) begin errors++; $display("FAIL settle_resume: got %0d/%0d expected 1/36", mv_n, exposure); end
    endtask

    task automatic test_back_to_back;
        run_frame(30'd100000, 22'd1000, 24'd0, 5, 0);
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL busy_in_divide: got %b expected 1", busy_mid); end
        checks++; if (mv_n !== 1 || ev_n !== 1) begin errors++; $display("FAIL drop_while_busy: got %0d/%0d expected 1/1", mv_n, ev_n); end
        checks++; if (mean !== 8'd100 || exposure !== 16'd72) begin errors++; $display("FAIL drop_result: got %0d/%0d expected 100/72", mean, exposure); end
    endtask

    task automatic test_enable_abort;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 10);
        checks++; if (busy_mid !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", busy_mid); end
        checks++; if (mv_n !== 0 || ev_n !== 0 || exposure !== 16'd72) begin errors++; $display("FAIL abort_hold: got %0d/%0d/%0d expected 0/0/72", mv_n, ev_n, exposure); end
    endtask

    task automatic test_reset_mid_divide;
        @(negedge pixclk);
        accum01 = 30'd100000; accum10 = 30'd100000; accum_count = 22'd1000; stats_done = 1'b1;
        @(posedge pixclk);
        @(negedge pixclk);
        stats_done = 1'b0;
        repeat (9) @(posedge pixclk);
        #3 reset = 1'b1;
        #1;
        checks++; if (exposure !== 16'd512 || mean !== 8'd0) begin errors++; $display("FAIL async_reset_values: got %0d/%0d expected 512/0", exposure, mean); end
        checks++; if ({busy, mean_valid, exposure_valid} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b expected 000", {busy, mean_valid, exposure_valid}); end
        @(negedge pixclk);
        reset = 1'b0;
        step_shift = 4'd3; exp_max = 16'd2000; exp_min = 16'd0;
        run_frame(30'd100000, 22'd1000, 24'd0, 0, 0);
        checks++; if (exposure !== 16'd576 || mean !== 8'd100 || ev_cyc !== 33) begin errors++; $display("FAIL post_reset_frame: got %0d/%0d/%0d expected 576/100/33", exposure, mean, ev_cyc); end
    endtask

    initial begin
        test_reset();
        test_increase();
        test_decrease();
        test_hold();
        test_clamp();
        test_sat_override();
        test_settle();
        test_back_to_back();
        test_enable_abort();
        test_reset_mid_divide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
